// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
// Module   : prog_loader
// Purpose  : Byte-serial program loader. Receives a framed byte stream
//            (2-byte word count, 3-byte little-endian 19-bit records and an
//            optional checksum byte), writes each word into instruction
//            memory, then pulses start to the controller. Framing errors are
//            reported through error/err_code, and start is withheld.
// Options  : LOADER_CHECKSUM_EN - adds the CHK state and the running XOR.
// Revision : 1.0 - initial release
// ============================================================================
module prog_loader #(
  parameter logic [11:0] BASE_ADDR = 12'h000,
  parameter int          MAX_WORDS = 4095
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_req,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        imem_wr_en,
  output logic [11:0] imem_wr_addr,
  output logic [18:0] imem_wr_data,
  output logic        start,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [1:0]  err_code
);

  localparam logic [12:0] c_MAX_WORDS = 13'(MAX_WORDS);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_HDR0  = 4'd1,
    S_HDR1  = 4'd2,
    S_B0    = 4'd3,
    S_B1    = 4'd4,
    S_B2    = 4'd5,
    S_WRITE = 4'd6,
    S_START = 4'd7,
    S_DONE  = 4'd8,
    S_ERR   = 4'd9
`ifdef LOADER_CHECKSUM_EN
    , S_CHK = 4'd10
`endif
  } state_t;

  state_t      r_state;
  state_t      w_nextState;
  logic [7:0]  r_cntLo;
  logic [11:0] r_count;
  logic [11:0] r_wordIdx;
  logic [11:0] r_wrAddr;
  logic [18:0] r_word;
  logic [1:0]  r_errCode;
  logic [1:0]  w_errCode;
  logic        w_errSet;
  logic        w_xfer;
  logic        w_loadAccept;
  logic        w_lastWord;
  logic [11:0] w_count;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  r_xor;
`endif

  assign w_xfer       = byte_valid && byte_ready;
  assign w_loadAccept = load_req &&
                        ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR));
  assign w_count      = {byte_in[3:0], r_cntLo};
  assign w_lastWord   = ({1'b0, r_wordIdx} + 13'd1) >= {1'b0, r_count};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_nextState;
  end

  // Next-state logic and error classification.
  always_comb begin
    w_nextState = r_state;
    w_errSet    = 1'b0;
    w_errCode   = 2'b00;
    case (r_state)
      S_IDLE, S_DONE, S_ERR: if (w_loadAccept) w_nextState = S_HDR0;
      S_HDR0: if (w_xfer) w_nextState = S_HDR1;
      S_HDR1: begin
        if (w_xfer) begin
          if ((byte_in[7:4] != 4'd0) || (w_count == 12'd0) ||
              ({1'b0, w_count} > c_MAX_WORDS)) begin
            w_nextState = S_ERR;
            w_errSet    = 1'b1;
            w_errCode   = 2'b01;
          end else begin
            w_nextState = S_B0;
          end
        end
      end
      S_B0: if (w_xfer) w_nextState = S_B1;
      S_B1: if (w_xfer) w_nextState = S_B2;
      S_B2: begin
        if (w_xfer) begin
          if (byte_in[7:3] != 5'd0) begin
            w_nextState = S_ERR;
            w_errSet    = 1'b1;
            w_errCode   = 2'b10;
          end else begin
            w_nextState = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        if (!w_lastWord)     w_nextState = S_B0;
`ifdef LOADER_CHECKSUM_EN
        else                 w_nextState = S_CHK;
`else
        else                 w_nextState = S_START;
`endif
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHK: begin
        if (w_xfer) begin
          if (byte_in == r_xor) begin
            w_nextState = S_START;
          end else begin
            w_nextState = S_ERR;
            w_errSet    = 1'b1;
            w_errCode   = 2'b11;
          end
        end
      end
`endif
      S_START: w_nextState = S_DONE;
      default: w_nextState = S_IDLE;
    endcase
  end

  // Datapath: header latch, word assembly, index/address and error code.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cntLo   <= 8'd0;
      r_count   <= 12'd0;
      r_wordIdx <= 12'd0;
      r_wrAddr  <= 12'd0;
      r_word    <= 19'd0;
      r_errCode <= 2'b00;
    end else begin
      if (w_loadAccept) begin
        r_wordIdx <= 12'd0;
        r_wrAddr  <= BASE_ADDR;
        r_errCode <= 2'b00;
      end
      if (w_errSet) r_errCode <= w_errCode;
      if (w_xfer) begin
        case (r_state)
          S_HDR0:  r_cntLo         <= byte_in;
          S_HDR1:  r_count         <= w_count;
          S_B0:    r_word[7:0]     <= byte_in;
          S_B1:    r_word[15:8]    <= byte_in;
          S_B2:    r_word[18:16]   <= byte_in[2:0];
          default: ;
        endcase
      end
      if (r_state == S_WRITE) begin
        r_wordIdx <= r_wordIdx + 12'd1;
        r_wrAddr  <= r_wrAddr + 12'd1;
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  // Running XOR over all accepted header and payload bytes.
  always_ff @(posedge clk) begin
    if (rst)                              r_xor <= 8'd0;
    else if (w_loadAccept)                r_xor <= 8'd0;
    else if (w_xfer && r_state != S_CHK)  r_xor <= r_xor ^ byte_in;
  end
`endif

  // Output decode straight from the state register.
  always_comb begin
    byte_ready = (r_state == S_HDR0) || (r_state == S_HDR1) || (r_state == S_B0) ||
                 (r_state == S_B1)   || (r_state == S_B2);
`ifdef LOADER_CHECKSUM_EN
    byte_ready = byte_ready || (r_state == S_CHK);
`endif
    imem_wr_en = (r_state == S_WRITE);
    start      = (r_state == S_START);
    done       = (r_state == S_DONE);
    error      = (r_state == S_ERR);
    busy       = !((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR));
  end

  assign imem_wr_addr = r_wrAddr;
  assign imem_wr_data = r_word;
  assign err_code     = r_errCode;

endmodule
`default_nettype wire
